oc_flash_master: RTL and testbench

- Avalon-MM initiator that drives the on-chip flash IP's data port and CSR port from a simple command/response interface.
- Sequences word reads (burst 1 or 2), single-word writes, and sector or page erases.
- Handles CSR write-protect unlock and relock, busy polling, and status checking, so user logic never touches CSR bit fields.
- Sits between user/boot logic and the flash IP instance.

---
 rtl/oc_flash_master.sv | 216 +++++++++++++++++++++
 tb/tb_oc_flash_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_flash_master.sv
// Avalon-MM initiator for the on-chip flash IP: sequences data-port reads/writes,
// CSR write-protect unlock/relock, sector/page erase and busy polling.
module oc_flash_master #(
    parameter int ADDR_W         = 16,
    parameter int POLL_LIMIT     = 1048575,
    parameter int CSR_RD_LATENCY = 1,
    parameter bit RELOCK         = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_burst,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avmm_data_addr,
    output logic              avmm_data_read,
    output logic              avmm_data_write,
    output logic [31:0]       avmm_data_writedata,
    output logic [1:0]        avmm_data_burstcount,
    input  logic [31:0]       avmm_data_readdata,
    input  logic              avmm_data_waitrequest,
    input  logic              avmm_data_readdatavalid,
    output logic              avmm_csr_addr,
    output logic              avmm_csr_read,
    output logic              avmm_csr_write,
    output logic [31:0]       avmm_csr_writedata,
    input  logic [31:0]       avmm_csr_readdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_UNLOCK,
        S_WR_REQ,
        S_ER_REQ,
        S_POLL,
        S_POLL_WAIT,
        S_RELOCK,
        S_FINISH
    } state_t;

    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_SE = 2'd2;

    localparam int             PCW      = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);
    localparam logic [1:0]     LAT      = 2'(CSR_RD_LATENCY);

    // Control register: [27:23] sector write-protect, [22:20] sector erase, [19:0] page erase
    localparam logic [31:0] CTRL_UNLOCK = 32'h007F_FFFF;
    localparam logic [31:0] CTRL_LOCK   = 32'h0FFF_FFFF;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_burst;
    logic [31:0]        r_wdata;
    logic               r_beat;
    logic [1:0]         r_lat;
    logic [PCW-1:0]     r_polls;
    logic               r_err;

    logic               w_accept;
    logic               w_sec_bad;
    logic [1:0]         w_burst;
    logic               w_busy;
    logic               w_pass;
    logic               w_sample;
    logic               w_repoll;
    logic               w_last_beat;
    logic [31:0]        w_erase_ctrl;
    logic               w_unused;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_sec_bad   = (cmd_addr[2:0] == 3'd0) || (cmd_addr[2:0] > 3'd5);
    assign w_burst     = (cmd_burst == 2'd0) ? 2'd1 : (cmd_burst == 2'd3) ? 2'd2 : cmd_burst;
    assign w_busy      = |avmm_csr_readdata[1:0];
    assign w_pass      = (r_op == OP_WR) ? avmm_csr_readdata[3] : avmm_csr_readdata[4];
    assign w_sample    = (r_state == S_POLL_WAIT) && (r_lat == LAT);
    assign w_repoll    = w_busy && (r_polls != POLL_MAX);
    assign w_last_beat = avmm_data_readdatavalid && (r_beat || (r_burst == 2'd1));
    assign w_erase_ctrl = (r_op == OP_SE) ? {9'h0, r_addr[2:0], 20'hF_FFFF}
                                          : {9'h0, 3'b111, 20'(r_addr)};
    assign w_unused    = ^{avmm_csr_readdata[31:5], avmm_csr_readdata[2]};

    assign avmm_data_addr      = r_addr;
    assign avmm_data_writedata = r_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next               = r_state;
        cmd_ready            = 1'b0;
        rsp_valid            = 1'b0;
        rsp_data             = '0;
        done                 = 1'b0;
        error                = 1'b0;
        avmm_data_read       = 1'b0;
        avmm_data_write      = 1'b0;
        avmm_data_burstcount = 2'd0;
        avmm_csr_addr        = 1'b0;
        avmm_csr_read        = 1'b0;
        avmm_csr_write       = 1'b0;
        avmm_csr_writedata   = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RD:   w_next = S_RD_REQ;
                        OP_SE:   w_next = w_sec_bad ? S_FINISH : S_UNLOCK;
                        default: w_next = S_UNLOCK;
                    endcase
                end
            end
            S_RD_REQ: begin
                avmm_data_read       = 1'b1;
                avmm_data_burstcount = r_burst;
                if (!avmm_data_waitrequest) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                rsp_valid = avmm_data_readdatavalid;
                rsp_data  = avmm_data_readdatavalid ? avmm_data_readdata : '0;
                if (w_last_beat) w_next = S_FINISH;
            end
            S_UNLOCK: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = CTRL_UNLOCK;
                w_next             = (r_op == OP_WR) ? S_WR_REQ : S_ER_REQ;
            end
            S_WR_REQ: begin
                avmm_data_write      = 1'b1;
                avmm_data_burstcount = 2'd1;
                if (!avmm_data_waitrequest) w_next = S_POLL;
            end
            S_ER_REQ: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = w_erase_ctrl;
                w_next             = S_POLL;
            end
            S_POLL: begin
                avmm_csr_read = 1'b1;
                w_next        = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (w_sample) begin
                    if (w_repoll)    w_next = S_POLL;
                    else if (RELOCK) w_next = S_RELOCK;
                    else             w_next = S_FINISH;
                end
            end
            S_RELOCK: begin
                avmm_csr_write     = 1'b1;
                avmm_csr_addr      = 1'b1;
                avmm_csr_writedata = CTRL_LOCK;
                w_next             = S_FINISH;
            end
            S_FINISH: begin
                done   = 1'b1;
                error  = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_burst <= '0;
            r_wdata <= '0;
            r_beat  <= 1'b0;
            r_lat   <= '0;
            r_polls <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_addr  <= cmd_addr;
                r_burst <= w_burst;
                r_wdata <= cmd_wdata;
                r_beat  <= 1'b0;
                r_polls <= '0;
                r_err   <= (cmd_op == OP_SE) && w_sec_bad;
            end
            if ((r_state == S_RD_WAIT) && avmm_data_readdatavalid) r_beat <= 1'b1;
            // r_lat counts cycles since the status read strobe; status is valid when it hits LAT
            if (r_state == S_POLL) begin
                r_polls <= r_polls + 1'b1;
                r_lat   <= 2'd1;
            end else if ((r_state == S_POLL_WAIT) && (r_lat != LAT)) begin
                r_lat <= r_lat + 2'd1;
            end
            if (w_sample && !w_repoll) r_err <= w_busy || !w_pass;
        end
    end

endmodule

// File: tb/tb_oc_flash_master.sv
// Randomized bench for oc_flash_master: a behavioural flash model answers both ports,
// and each command's outcome is predicted from the command and the scripted status.
module tb_oc_flash_master;
    localparam int AW     = 16;
    localparam int LIMIT  = 12;
    localparam int LAT    = 2;
    localparam int BUDGET = 400;
    localparam logic [31:0] UNLOCK_W = 32'h007F_FFFF;
    localparam logic [31:0] LOCK_W   = 32'h0FFF_FFFF;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [1:0]    cmd_burst = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          done;
    logic          error;
    logic [AW-1:0] avmm_data_addr;
    logic          avmm_data_read;
    logic          avmm_data_write;
    logic [31:0]   avmm_data_writedata;
    logic [1:0]    avmm_data_burstcount;
    logic [31:0]   avmm_data_readdata = '0;
    logic          avmm_data_waitrequest = 1'b0;
    logic          avmm_data_readdatavalid = 1'b0;
    logic          avmm_csr_addr;
    logic          avmm_csr_read;
    logic          avmm_csr_write;
    logic [31:0]   avmm_csr_writedata;
    logic [31:0]   avmm_csr_readdata = '0;

    always #5 clock = ~clock;

    oc_flash_master #(.ADDR_W(AW), .POLL_LIMIT(LIMIT), .CSR_RD_LATENCY(LAT), .RELOCK(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .error(error),
        .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
        .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
        .avmm_data_burstcount(avmm_data_burstcount), .avmm_data_readdata(avmm_data_readdata),
        .avmm_data_waitrequest(avmm_data_waitrequest),
        .avmm_data_readdatavalid(avmm_data_readdatavalid),
        .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
        .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
        .avmm_csr_readdata(avmm_csr_readdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flash model state and per-command observation logs
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          m_wait = 0, m_nbusy = 0, wait_left = 0;
    logic [31:0] m_final = '0;
    bit          m_spur = 1'b0;
    logic [31:0] q_rsp[$];
    logic [31:0] q_csrw[$];
    int          beat_due[$];
    logic [31:0] beat_val[$];
    int          csr_due[$];
    logic [31:0] csr_val[$];
    int          n_stat, n_rd, n_wr, rd_held, viol, spur_rsp, done_cnt = 0;
    logic [1:0]  rd_burst;
    logic [15:0] rd_addr, wr_addr;
    logic [31:0] wr_data;
    bit          seen_done;
    logic        done_err, ready_at_done;

    task automatic clear_logs();
        q_rsp.delete(); q_csrw.delete();
        beat_due.delete(); beat_val.delete(); csr_due.delete(); csr_val.delete();
        n_stat = 0; n_rd = 0; n_wr = 0; rd_held = 0; viol = 0; spur_rsp = 0;
        rd_burst = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        seen_done = 1'b0; done_err = 1'b0; ready_at_done = 1'b0;
    endtask

    initial begin : model
        logic [31:0] v;
        logic [7:0]  ix;
        int          lat, b;
        forever begin
            @(negedge clock);
            cyc++;
            if (avmm_csr_read && avmm_csr_write) viol++;
            if (avmm_data_read && avmm_data_write) viol++;
            if (avmm_csr_write) begin
                if (avmm_csr_addr !== 1'b1) viol++;
                q_csrw.push_back(avmm_csr_writedata);
            end
            if (avmm_csr_read) begin
                if (avmm_csr_addr !== 1'b0) viol++;
                n_stat++;
                v = (n_stat <= m_nbusy) ? (($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)))
                                        : m_final;
                csr_due.push_back(cyc + LAT);
                csr_val.push_back(v);
            end
            avmm_data_waitrequest = 1'b0;
            if (avmm_data_read) rd_held++;
            if (avmm_data_read || avmm_data_write) begin
                if (wait_left > 0) begin
                    avmm_data_waitrequest = 1'b1;
                    wait_left--;
                end else if (avmm_data_read) begin
                    n_rd++;
                    rd_burst = avmm_data_burstcount;
                    rd_addr  = avmm_data_addr;
                    b   = (avmm_data_burstcount == 2'd2) ? 2 : 1;
                    lat = $urandom_range(1, 3);
                    for (int k = 0; k < b; k++) begin
                        ix = avmm_data_addr[7:0] + 8'(k);
                        beat_due.push_back(cyc + lat + k);
                        beat_val.push_back(mem[ix]);
                    end
                end else begin
                    n_wr++;
                    wr_addr = avmm_data_addr;
                    wr_data = avmm_data_writedata;
                    mem[avmm_data_addr[7:0]] = avmm_data_writedata;
                end
            end
            avmm_data_readdatavalid = 1'b0;
            avmm_data_readdata      = $urandom;
            if (beat_due.size() > 0 && beat_due[0] == cyc) begin
                void'(beat_due.pop_front());
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata      = beat_val.pop_front();
            end else if (m_spur && $urandom_range(0, 5) == 0) begin
                avmm_data_readdatavalid = 1'b1;
            end
            // between scheduled responses the CSR bus shows a busy pattern
            avmm_csr_readdata = 32'h0000_0003;
            if (csr_due.size() > 0 && csr_due[0] == cyc) begin
                void'(csr_due.pop_front());
                avmm_csr_readdata = csr_val.pop_front();
            end
            #1;
            if (rsp_valid) begin
                if (m_spur) spur_rsp++;
                else q_rsp.push_back(rsp_data);
            end
            if (done) begin
                done_cnt++;
                seen_done     = 1'b1;
                done_err      = error;
                ready_at_done = cmd_ready;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [1:0] burst,
                         input logic [31:0] wd);
        @(negedge clock); #2;
        chk("ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_burst = burst; cmd_wdata = wd;
        @(posedge clock); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
        cmd_burst = 2'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [1:0] burst,
                           input logic [31:0] wd, input int wt, input int nb, input logic [31:0] fin);
        logic [31:0] e_rsp[$];
        logic [31:0] e_csr[$];
        logic [2:0]  sec;
        logic [7:0]  ix;
        int          e_stat, e_nrd, e_nwr, eb, n, d0;
        logic        e_err;
        bit          bad_sec, tmo;
        sec     = addr[2:0];
        eb      = (burst == 2'd0) ? 1 : (burst == 2'd3) ? 2 : int'(burst);
        bad_sec = (op == 2'd2) && (sec == 3'd0 || sec > 3'd5);
        tmo     = nb >= LIMIT;
        e_stat = 0; e_nrd = 0; e_nwr = 0; e_err = 1'b0;
        if (op == 2'd0) begin
            e_nrd = 1;
            for (int k = 0; k < eb; k++) begin
                ix = addr[7:0] + 8'(k);
                e_rsp.push_back(mem[ix]);
            end
        end else if (bad_sec) begin
            e_err = 1'b1;
        end else begin
            e_csr.push_back(UNLOCK_W);
            if (op == 2'd2) e_csr.push_back({9'h0, sec, 20'hF_FFFF});
            if (op == 2'd3) e_csr.push_back({9'h0, 3'b111, 4'h0, addr});
            e_csr.push_back(LOCK_W);
            e_stat = tmo ? LIMIT : nb + 1;
            e_err  = tmo ? 1'b1 : !((op == 2'd1) ? fin[3] : fin[4]);
            e_nwr  = (op == 2'd1) ? 1 : 0;
        end
        clear_logs();
        m_wait = wt; wait_left = wt; m_nbusy = nb; m_final = fin; m_spur = (op != 2'd0);
        d0 = done_cnt;
        issue(op, addr, burst, wd);
        n = 0;
        while (!seen_done && n < BUDGET) begin
            @(negedge clock); #2;
            n++;
        end
        chk("done_seen", 32'(seen_done), 1);
        chk("error", 32'(done_err), 32'(e_err));
        chk("ready_in_done", 32'(ready_at_done), 0);
        chk("rsp_n", 32'(q_rsp.size()), 32'(e_rsp.size()));
        for (int i = 0; i < e_rsp.size() && i < q_rsp.size(); i++) chk("rsp_data", q_rsp[i], e_rsp[i]);
        chk("csrw_n", 32'(q_csrw.size()), 32'(e_csr.size()));
        for (int i = 0; i < e_csr.size() && i < q_csrw.size(); i++) chk("csrw_data", q_csrw[i], e_csr[i]);
        chk("stat_reads", 32'(n_stat), 32'(e_stat));
        chk("rd_n", 32'(n_rd), 32'(e_nrd));
        if (e_nrd > 0) begin
            chk("rd_addr", 32'(rd_addr), 32'(addr));
            chk("rd_burst", 32'(rd_burst), 32'(eb));
            chk("rd_held", 32'(rd_held), 32'(wt + 1));
        end
        chk("wr_n", 32'(n_wr), 32'(e_nwr));
        if (e_nwr > 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(addr));
            chk("wr_data", wr_data, wd);
        end
        chk("excl_viol", 32'(viol), 0);
        chk("spur_rsp", 32'(spur_rsp), 0);
        @(negedge clock); #2;
        chk("ready_after", 32'(cmd_ready), 1);
        chk("done_pulses", 32'(done_cnt - d0), 1);
    endtask

    initial begin : stim
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        clear_logs();
        #1;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_strobes", 32'({avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write,
                                done, error, rsp_valid}), 0);
        chk("rst_bus", 32'({avmm_data_addr, avmm_data_burstcount}), 0);
        chk("rst_csrw", avmm_csr_writedata, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h11] = 32'h1234_5678;
        run_cmd(2'd0, 16'h0010, 2'd2, 32'h0, 3, 0, 32'h0);
        run_cmd(2'd1, 16'h0100, 2'd0, 32'hA5A5_A5A5, 1, 5, 32'h08);
        run_cmd(2'd2, 16'h0002, 2'd0, 32'h0, 0, 10, 32'h10);
        run_cmd(2'd3, 16'h0040, 2'd0, 32'h0, 0, 0, 32'h00);
        run_cmd(2'd1, 16'h0022, 2'd0, 32'h1357_9BDF, 0, 50, 32'h08);
        run_cmd(2'd2, 16'h0006, 2'd0, 32'h0, 0, 0, 32'h10);
        run_cmd(2'd2, 16'h0000, 2'd0, 32'h0, 0, 0, 32'h10);
        run_cmd(2'd0, 16'h00FF, 2'd3, 32'h0, 0, 0, 32'h0);
        run_cmd(2'd0, 16'h0033, 2'd0, 32'h0, 2, 0, 32'h0);
        run_cmd(2'd1, 16'h0044, 2'd0, 32'hCAFE_F00D, 2, LIMIT - 1, 32'h00);

        // reset while polling a write
        clear_logs();
        m_wait = 0; wait_left = 0; m_nbusy = 100; m_final = 32'h08; m_spur = 1'b0;
        issue(2'd1, 16'h0055, 2'd0, 32'h0BAD_CAFE);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write,
                                    done, error, rsp_valid}), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        d0 = done_cnt;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
        chk("mid_rst_ready_after", 32'(cmd_ready), 1);
        mem[8'h60] = 32'h0F0F_1234;
        run_cmd(2'd0, 16'h0060, 2'd1, 32'h0, 1, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 16'($urandom), 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 14), $urandom & 32'hFFFF_FFFC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
